// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, fetches words over a req/valid handshake and loads IF/ID.
// Handles wait-stated memory, stall hold buffering and redirect with in-flight squash.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemValid,
  input  logic [31:0] IMemData,
  output logic        IFID_Valid,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic [15:0] IFID_Imm16
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DROP  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  state_t      state_r, state_n_s;
  logic [31:0] pc_r, pc_n_s;
  logic [31:0] drop_addr_r, drop_addr_n_s;
  logic [31:0] hold_instr_r, hold_instr_n_s;
  logic [31:0] hold_pc4_r, hold_pc4_n_s;
  logic        ifid_valid_r, ifid_valid_n_s;
  logic [31:0] ifid_instr_r, ifid_instr_n_s;
  logic [31:0] ifid_pc4_r, ifid_pc4_n_s;
  logic        req_s;
  logic        handshake_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] target_s;

  // Request is a Moore function of state; Reset only gates it off.
  always_comb begin
    req_s = 1'b0;
    case (state_r)
      ST_FETCH: req_s = ~Reset;
      ST_DROP:  req_s = ~Reset;
      ST_HOLD:  req_s = 1'b0;
      default:  req_s = 1'b0;
    endcase
  end

  // Address mux: DROP keeps presenting the abandoned address until its response lands.
  always_comb begin
    IMemAddr = pc_r;
    case (state_r)
      ST_DROP: IMemAddr = drop_addr_r;
      default: IMemAddr = pc_r;
    endcase
  end

  assign IMemReq          = req_s;
  assign handshake_s      = req_s & IMemValid;
  assign pc_plus4_s       = pc_r + 32'd4;
  assign target_s         = word_align(RedirectPC);
  assign IFID_Valid       = ifid_valid_r;
  assign IFID_Instruction = ifid_instr_r;
  assign IFID_PCPlus4     = ifid_pc4_r;
  assign IFID_Imm16       = ifid_instr_r[15:0];

  // Next-state, PC, hold buffer and IF/ID update; Redirect outranks Stall.
  always_comb begin
    state_n_s      = state_r;
    pc_n_s         = pc_r;
    drop_addr_n_s  = drop_addr_r;
    hold_instr_n_s = hold_instr_r;
    hold_pc4_n_s   = hold_pc4_r;
    ifid_valid_n_s = ifid_valid_r;
    ifid_instr_n_s = ifid_instr_r;
    ifid_pc4_n_s   = ifid_pc4_r;
    case (state_r)
      ST_FETCH: begin
        if (handshake_s) begin
          if (Redirect) begin
            pc_n_s         = target_s;
            ifid_valid_n_s = 1'b0;
            ifid_instr_n_s = 32'h0000_0000;
            ifid_pc4_n_s   = 32'h0000_0000;
          end else if (Stall) begin
            hold_instr_n_s = IMemData;
            hold_pc4_n_s   = pc_plus4_s;
            state_n_s      = ST_HOLD;
          end else begin
            pc_n_s         = pc_plus4_s;
            ifid_valid_n_s = 1'b1;
            ifid_instr_n_s = IMemData;
            ifid_pc4_n_s   = pc_plus4_s;
          end
        end else begin
          if (Redirect) begin
            drop_addr_n_s  = pc_r;
            pc_n_s         = target_s;
            state_n_s      = ST_DROP;
            ifid_valid_n_s = 1'b0;
            ifid_instr_n_s = 32'h0000_0000;
            ifid_pc4_n_s   = 32'h0000_0000;
          end else if (Stall) begin
            state_n_s = ST_FETCH;
          end else begin
            ifid_valid_n_s = 1'b0;
            ifid_instr_n_s = 32'h0000_0000;
            ifid_pc4_n_s   = 32'h0000_0000;
          end
        end
      end
      ST_DROP: begin
        if (handshake_s) begin
          state_n_s = ST_FETCH;
        end else begin
          state_n_s = ST_DROP;
        end
        if (Redirect) begin
          pc_n_s         = target_s;
          ifid_valid_n_s = 1'b0;
          ifid_instr_n_s = 32'h0000_0000;
          ifid_pc4_n_s   = 32'h0000_0000;
        end else if (!Stall) begin
          ifid_valid_n_s = 1'b0;
          ifid_instr_n_s = 32'h0000_0000;
          ifid_pc4_n_s   = 32'h0000_0000;
        end else begin
          ifid_valid_n_s = ifid_valid_r;
        end
      end
      ST_HOLD: begin
        if (Redirect) begin
          pc_n_s         = target_s;
          hold_instr_n_s = 32'h0000_0000;
          hold_pc4_n_s   = 32'h0000_0000;
          state_n_s      = ST_FETCH;
          ifid_valid_n_s = 1'b0;
          ifid_instr_n_s = 32'h0000_0000;
          ifid_pc4_n_s   = 32'h0000_0000;
        end else if (!Stall) begin
          pc_n_s         = pc_plus4_s;
          state_n_s      = ST_FETCH;
          ifid_valid_n_s = 1'b1;
          ifid_instr_n_s = hold_instr_r;
          ifid_pc4_n_s   = hold_pc4_r;
        end else begin
          state_n_s = ST_HOLD;
        end
      end
      default: begin
        state_n_s      = ST_FETCH;
        ifid_valid_n_s = 1'b0;
        ifid_instr_n_s = 32'h0000_0000;
        ifid_pc4_n_s   = 32'h0000_0000;
      end
    endcase
  end

  // State, PC, hold buffer and IF/ID registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r      <= ST_FETCH;
      pc_r         <= RESET_PC;
      drop_addr_r  <= 32'h0000_0000;
      hold_instr_r <= 32'h0000_0000;
      hold_pc4_r   <= 32'h0000_0000;
      ifid_valid_r <= 1'b0;
      ifid_instr_r <= 32'h0000_0000;
      ifid_pc4_r   <= 32'h0000_0000;
    end else begin
      state_r      <= state_n_s;
      pc_r         <= pc_n_s;
      drop_addr_r  <= drop_addr_n_s;
      hold_instr_r <= hold_instr_n_s;
      hold_pc4_r   <= hold_pc4_n_s;
      ifid_valid_r <= ifid_valid_n_s;
      ifid_instr_r <= ifid_instr_n_s;
      ifid_pc4_r   <= ifid_pc4_n_s;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: wait-state memory model, IF/ID scoreboard,
// and scenario tasks with cycle-accurate fetch address checks.
module tb_instruction_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Redirect;
  logic [31:0] RedirectPC;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemValid = 1'b0;
  logic [31:0] IMemData = 32'h0000_0000;
  logic        IFID_Valid;
  logic [31:0] IFID_Instruction, IFID_PCPlus4;
  logic [15:0] IFID_Imm16;

  logic        b_valid, b_req, b_ifid_valid;
  logic [31:0] b_data, b_addr, b_instr, b_pc4;
  logic [15:0] b_imm;

  int wait_states = 0;
  int cnt = 0;
  int n_checks = 0;
  int n_pass = 0;
  logic mon_en = 1'b0;
  logic stall_q = 1'b0;
  logic reset_q = 1'b1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  instruction_fetch_stage dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemValid(IMemValid), .IMemData(IMemData),
    .IFID_Valid(IFID_Valid), .IFID_Instruction(IFID_Instruction),
    .IFID_PCPlus4(IFID_PCPlus4), .IFID_Imm16(IFID_Imm16)
  );

  instruction_fetch_stage #(.RESET_PC(32'h0040_0000)) dut_b (
    .Clk(Clk), .Reset(Reset), .Stall(1'b0), .Redirect(1'b0), .RedirectPC(32'h0000_0000),
    .IMemReq(b_req), .IMemAddr(b_addr), .IMemValid(b_valid), .IMemData(b_data),
    .IFID_Valid(b_ifid_valid), .IFID_Instruction(b_instr),
    .IFID_PCPlus4(b_pc4), .IFID_Imm16(b_imm)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h2008_FFFF;
    return a;
  endfunction

  // Memory model: responds after wait_states cycles of continuous request
  always @(posedge Clk) begin
    if (Reset || !IMemReq || IMemValid) cnt <= 0;
    else cnt <= cnt + 1;
    stall_q <= Stall;
    reset_q <= Reset;
  end

  always @(negedge Clk) begin
    IMemValid = IMemReq && (cnt == wait_states);
    IMemData  = IMemValid ? mem_word(IMemAddr) : 32'hDEAD_BEEF;
  end

  // Scoreboard: each unstalled edge either bubbles IF/ID or delivers the next expected word
  always @(negedge Clk) begin
    if (mon_en) begin
      if (IFID_Valid === 1'b1 && !stall_q && !reset_q) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL ifid_unexpected: got instr %h pc4 %h, required no delivery", IFID_Instruction, IFID_PCPlus4);
        end else begin
          mon_e = sb_q.pop_front();
          if (IFID_Instruction !== mon_e.instr || IFID_PCPlus4 !== mon_e.pc4 || IFID_Imm16 !== mon_e.instr[15:0])
            $display("FAIL ifid_delivery: got instr %h pc4 %h imm %h, required instr %h pc4 %h",
                     IFID_Instruction, IFID_PCPlus4, IFID_Imm16, mon_e.instr, mon_e.pc4);
          else n_pass++;
        end
      end else if (IFID_Valid !== 1'b1) begin
        n_checks++;
        if (IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0 || IFID_PCPlus4 !== 32'h0)
          $display("FAIL ifid_bubble: got valid %b instr %h pc4 %h, required all zero", IFID_Valid, IFID_Instruction, IFID_PCPlus4);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++; if (IMemReq !== 1'b0) $display("FAIL rst_req: got %b required 0", IMemReq); else n_pass++;
    n_checks++; if (b_req !== 1'b0) $display("FAIL rst_req_b: got %b required 0", b_req); else n_pass++;
    n_checks++; if (IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0 || IFID_PCPlus4 !== 32'h0 || IFID_Imm16 !== 16'h0)
      $display("FAIL rst_ifid: got %b %h %h %h required zeros", IFID_Valid, IFID_Instruction, IFID_PCPlus4, IFID_Imm16); else n_pass++;
    n_checks++; if (b_ifid_valid !== 1'b0 || b_instr !== 32'h0 || b_pc4 !== 32'h0 || b_imm !== 16'h0)
      $display("FAIL rst_ifid_b: got %b %h %h %h required zeros", b_ifid_valid, b_instr, b_pc4, b_imm); else n_pass++;
    mon_en = 1'b1;
    Reset = 1'b0;
    #1;
    n_checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) $display("FAIL rst_first_req: got %b %h required 1 00000000", IMemReq, IMemAddr); else n_pass++;
    n_checks++; if (b_req !== 1'b1 || b_addr !== 32'h0040_0000) $display("FAIL rst_pc_b: got %b %h required 1 00400000", b_req, b_addr); else n_pass++;
  endtask

  task automatic test_zero_wait();
    logic [31:0] a;
    wait_states = 0;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i) << 2;
      sb_q.push_back('{instr: a, pc4: a + 32'd4});
    end
    for (int i = 0; i < 4; i++) begin
      a = 32'(i) << 2;
      n_checks++; if (IMemAddr !== a || IMemReq !== 1'b1) $display("FAIL zw_addr: got %b %h required 1 %h", IMemReq, IMemAddr, a); else n_pass++;
      tick();
      n_checks++; if (IFID_Valid !== 1'b1) $display("FAIL zw_valid: got %b required 1", IFID_Valid); else n_pass++;
    end
  endtask

  task automatic test_wait_states();
    Redirect = 1'b1; RedirectPC = 32'h0000_000B;
    tick();
    Redirect = 1'b0; wait_states = 2;
    sb_q.push_back('{instr: 32'h8, pc4: 32'hC});
    n_checks++; if (IMemAddr !== 32'h8 || IFID_Valid !== 1'b0) $display("FAIL ws_start: got addr %h valid %b required 00000008 0", IMemAddr, IFID_Valid); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++; if (IMemAddr !== 32'h8 || IFID_Valid !== 1'b0) $display("FAIL ws_wait: got addr %h valid %b required 00000008 0", IMemAddr, IFID_Valid); else n_pass++;
    end
    tick();
    n_checks++; if (IFID_Valid !== 1'b1 || IFID_Instruction !== 32'h8 || IFID_PCPlus4 !== 32'hC || IMemAddr !== 32'hC)
      $display("FAIL ws_done: got %b %h %h addr %h required 1 8 C addr C", IFID_Valid, IFID_Instruction, IFID_PCPlus4, IMemAddr); else n_pass++;
  endtask

  task automatic test_stall();
    wait_states = 0;
    sb_q.push_back('{instr: 32'hC, pc4: 32'h10});
    tick();
    Stall = 1'b1;
    sb_q.push_back('{instr: 32'h2008_FFFF, pc4: 32'h14});
    tick();
    for (int s = 0; s < 3; s++) begin
      n_checks++; if (IMemReq !== 1'b0 || IFID_Instruction !== 32'hC || IFID_PCPlus4 !== 32'h10)
        $display("FAIL stall_hold: got req %b instr %h pc4 %h required 0 C 10", IMemReq, IFID_Instruction, IFID_PCPlus4); else n_pass++;
      if (s != 2) tick();
    end
    Stall = 1'b0;
    tick();
    n_checks++; if (IFID_Instruction !== 32'h2008_FFFF || IFID_Imm16 !== 16'hFFFF || IFID_PCPlus4 !== 32'h14)
      $display("FAIL stall_release: got %h %h %h required 2008ffff ffff 14", IFID_Instruction, IFID_Imm16, IFID_PCPlus4); else n_pass++;
    n_checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h14) $display("FAIL stall_next_addr: got %b %h required 1 14", IMemReq, IMemAddr); else n_pass++;
  endtask

  task automatic test_redirect_drop();
    Redirect = 1'b1; RedirectPC = 32'h20;
    tick();
    Redirect = 1'b0; wait_states = 3;
    n_checks++; if (IMemAddr !== 32'h20) $display("FAIL rd_target: got %h required 20", IMemAddr); else n_pass++;
    tick();
    Redirect = 1'b1; RedirectPC = 32'h40;
    tick();
    Redirect = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h20 || IFID_Valid !== 1'b0)
        $display("FAIL rd_drop_addr: got %b %h valid %b required 1 20 0", IMemReq, IMemAddr, IFID_Valid); else n_pass++;
      tick();
    end
    n_checks++; if (IMemAddr !== 32'h40 || IFID_Valid !== 1'b0) $display("FAIL rd_after_drop: got %h valid %b required 40 0", IMemAddr, IFID_Valid); else n_pass++;
    wait_states = 0;
    sb_q.push_back('{instr: 32'h40, pc4: 32'h44});
    tick();
    n_checks++; if (IFID_Valid !== 1'b1 || IFID_PCPlus4 !== 32'h44) $display("FAIL rd_first: got %b %h required 1 44", IFID_Valid, IFID_PCPlus4); else n_pass++;
  endtask

  task automatic test_hold_redirect();
    Stall = 1'b1;
    tick();
    n_checks++; if (IMemReq !== 1'b0 || IFID_PCPlus4 !== 32'h44) $display("FAIL hr_hold: got req %b pc4 %h required 0 44", IMemReq, IFID_PCPlus4); else n_pass++;
    Redirect = 1'b1; RedirectPC = 32'h80;
    tick();
    n_checks++; if (IFID_Valid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 32'h80)
      $display("FAIL hr_redirect: got valid %b req %b addr %h required 0 1 80", IFID_Valid, IMemReq, IMemAddr); else n_pass++;
    Stall = 1'b0; Redirect = 1'b0;
    sb_q.push_back('{instr: 32'h80, pc4: 32'h84});
    tick();
    n_checks++; if (IFID_PCPlus4 !== 32'h84) $display("FAIL hr_target: got %h required 84", IFID_PCPlus4); else n_pass++;
  endtask

  task automatic test_wrap();
    Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
    tick();
    Redirect = 1'b0;
    n_checks++; if (IMemAddr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h required fffffffc", IMemAddr); else n_pass++;
    sb_q.push_back('{instr: 32'hFFFF_FFFC, pc4: 32'h0});
    sb_q.push_back('{instr: 32'h0, pc4: 32'h4});
    tick();
    n_checks++; if (IFID_Valid !== 1'b1 || IFID_PCPlus4 !== 32'h0 || IMemAddr !== 32'h0)
      $display("FAIL wrap_pc4: got %b %h addr %h required 1 0 0", IFID_Valid, IFID_PCPlus4, IMemAddr); else n_pass++;
    tick();
    n_checks++; if (IFID_Instruction !== 32'h0 || IFID_PCPlus4 !== 32'h4) $display("FAIL wrap_next: got %h %h required 0 4", IFID_Instruction, IFID_PCPlus4); else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    wait_states = 3;
    tick();
    Reset = 1'b1;
    #1;
    n_checks++; if (IMemReq !== 1'b0 || b_req !== 1'b0) $display("FAIL rmw_req: got %b %b required 0 0", IMemReq, b_req); else n_pass++;
    tick();
    n_checks++; if (IMemReq !== 1'b0 || IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0 || IFID_PCPlus4 !== 32'h0)
      $display("FAIL rmw_state: got req %b %b %h %h required zeros", IMemReq, IFID_Valid, IFID_Instruction, IFID_PCPlus4); else n_pass++;
    Reset = 1'b0; wait_states = 0;
    #1;
    n_checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) $display("FAIL rmw_restart: got %b %h required 1 0", IMemReq, IMemAddr); else n_pass++;
    n_checks++; if (b_req !== 1'b1 || b_addr !== 32'h0040_0000) $display("FAIL rmw_restart_b: got %b %h required 1 00400000", b_req, b_addr); else n_pass++;
    sb_q.push_back('{instr: 32'h0, pc4: 32'h4});
    tick();
    n_checks++; if (IFID_Valid !== 1'b1) $display("FAIL rmw_first: got %b required 1", IFID_Valid); else n_pass++;
    Stall = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0;
    b_valid = 1'b0; b_data = 32'h0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect_drop();
    test_hold_redirect();
    test_wrap();
    test_reset_mid_wait();
    n_checks++; if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d pending required 0", sb_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage of the pipelined MIPS datapath. Owns the PC, issues word fetches to instruction memory over a req/valid handshake, and loads the IF/ID pipeline register whose low 16 instruction bits drive the sign-extension unit in decode. Supports wait-stated memory, hazard stalls via a one-entry hold buffer, and branch/jump redirects with squash of in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high; sampled on Clk rising edge.
- Stall  in  1  from hazard unit; IF/ID must hold its contents.
- Redirect  in  1  branch/jump taken; resteer fetch and squash IF/ID.
- RedirectPC  in  32  target address; word aligned, bits [1:0] ignored (treated as 0).
- IMemReq  out  1  fetch request.
- IMemAddr  out  32  fetch address; stable while IMemReq high.
- IMemValid  in  1  memory response; transaction completes on an edge where IMemReq && IMemValid.
- IMemData  in  32  instruction word, valid in the completing cycle.
- IFID_Valid  out  1  IF/ID holds a real instruction.
- IFID_Instruction  out  32  fetched word; 32'h0 (nop) when IFID_Valid=0.
- IFID_PCPlus4  out  32  address of fetched word + 4; 0 when invalid.
- IFID_Imm16  out  16  IFID_Instruction[15:0], to sign extension.

## Operation
- State FETCH: IMemReq=1, IMemAddr=PC.
  - Handshake, Redirect=1: response discarded; PC<=RedirectPC; IF/ID<=bubble; stay FETCH.
  - Handshake, Stall=1: word and PC+4 captured in hold buffer; IF/ID unchanged; go HOLD.
  - Handshake, neither: IF/ID<={1, IMemData, PC+4}; PC<=PC+4; stay FETCH.
  - No handshake, Redirect=1: DropAddr<=PC; PC<=RedirectPC; IF/ID<=bubble; go DROP.
  - No handshake, Stall=1: IF/ID unchanged. No handshake, neither: IF/ID<=bubble.
- State DROP: IMemReq=1, IMemAddr=DropAddr (address of the abandoned fetch, kept stable). On handshake: response discarded, go FETCH. Further Redirect in DROP: PC<=RedirectPC, stay DROP. IF/ID: bubble unless Stall (hold); Redirect forces bubble.
- State HOLD: IMemReq=0. Stall=1, Redirect=0: hold everything. Stall=0, Redirect=0: IF/ID<=buffer, PC<=PC+4, go FETCH. Redirect=1 (any Stall): buffer dropped, PC<=RedirectPC, IF/ID<=bubble, go FETCH.
- Priority: Reset > Redirect > Stall > normal. Redirect always bubbles IF/ID even under Stall.
- Bubble = IFID_Valid 0, Instruction 0, PCPlus4 0.
- PC arithmetic modulo 2^32; PC 32'hFFFF_FFFC + 4 wraps to 0, IFID_PCPlus4 = 0.
- No instruction is ever delivered twice or skipped; every completed handshake is either delivered exactly once or explicitly discarded per rules above.

## Timing
- Reset (edge with Reset=1): PC=RESET_PC, state FETCH, hold buffer cleared, all IF/ID outputs 0. IMemReq forced 0 in any cycle Reset is high; first request in the cycle after Reset deasserts, IMemAddr=RESET_PC.
- Reset mid-transaction: outstanding fetch abandoned immediately; memory must tolerate dropped request.
- IMemReq/IMemAddr are Moore outputs of state and PC/DropAddr; no combinational path from IMemValid, Stall or Redirect.
- Zero-wait memory (IMemValid high same cycle as IMemReq): one instruction per clock, IF/ID updated the edge after handshake.
- Fetch-to-IF/ID latency: 1 edge after handshake (unstalled). HOLD release: IF/ID loads on first edge with Stall=0.
- Redirect to first target request: target appears on IMemAddr in the next cycle (FETCH) or after the dropped response completes (DROP).

## Test plan
- Reset, zero-wait memory returning word = address: IMemAddr 0,4,8,C on consecutive cycles; IFID_Instruction 0,4,8 with IFID_PCPlus4 4,8,C, one per cycle, IFID_Valid=1 from second cycle after reset release.
- 2-wait-state memory: IMemAddr held at 0x8 for 3 cycles, IFID_Valid 0 for 2 cycles then Instruction for 0x8, PCPlus4 0xC.
- Stall on handshake of word 32'h2008_FFFF at 0x10: IMemReq 0 for 3 stall cycles, IF/ID unchanged; on release IFID_Instruction=32'h2008_FFFF, IFID_Imm16=16'hFFFF, PCPlus4=0x14, next IMemAddr=0x14.
- Redirect to 0x40 while 3-wait fetch of 0x20 outstanding: IMemAddr stays 0x20 until response, that word never appears valid; next IMemAddr=0x40, IFID_PCPlus4=0x44.
- Redirect to 0x80 plus Stall=1 while in HOLD: buffered word discarded, IFID_Valid=0 next cycle, IMemAddr=0x80.
- Reset asserted mid-wait and RESET_PC=32'h0040_0000 variant; PC 0xFFFF_FFFC wrap: IMemReq 0 during Reset, then IMemAddr=0x0040_0000; wrapped fetch gives IFID_PCPlus4=0, next IMemAddr=0.
